// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multi-channel PWM block.
package pwm_pkg;

  typedef enum logic {EDGE, CENTER} pwm_mode_e;
  typedef enum logic {UP, DOWN} pwm_dir_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_CH = 4;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow and active duty registers plus the output compare flop.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_sh;
  logic [WIDTH-1:0] duty_act;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (wr) duty_sh <= din;
      // A write landing on the load cycle goes straight into the active register.
      if (load) duty_act <= wr ? din : duty_sh;
      pwm <= en & (cnt < duty_act);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter (edge or center
// aligned) with double-buffered period, mode and per-channel duty.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         center_mode,
  input  logic [WIDTH-1:0]             period,
  input  logic [NUM_CH-1:0]            duty_wr,
  input  logic [NUM_CH-1:0][WIDTH-1:0] duty_in,
  output logic [NUM_CH-1:0]            PWM_sig,
  output logic                         period_start
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  pwm_dir_e         dir;
  pwm_dir_e         dir_nxt;
  logic [WIDTH-1:0] per_act;
  pwm_mode_e        mode_act;
  logic             boundary;
  logic             load;

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (per_act == '0) begin
      cnt_nxt = '0;
      dir_nxt = UP;
    end else if (mode_act == EDGE) begin
      cnt_nxt = (cnt >= per_act) ? '0 : cnt + 1'b1;
      dir_nxt = UP;
    end else if (dir == UP) begin
      if (cnt >= per_act) begin
        cnt_nxt = cnt - 1'b1;
        // With P==1 the turn-around lands on 0, so direction stays up.
        dir_nxt = (cnt_nxt == '0) ? UP : DOWN;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      cnt_nxt = cnt - 1'b1;
      if (cnt_nxt == '0) dir_nxt = UP;
    end
  end

  assign boundary = (cnt_nxt == '0) && ((cnt != '0) || (per_act == '0));
  // While disabled the active registers track their sources every cycle.
  assign load     = ~en | boundary;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir          <= UP;
      per_act      <= '0;
      mode_act     <= EDGE;
      period_start <= 1'b0;
    end else if (!en) begin
      cnt          <= '0;
      dir          <= UP;
      per_act      <= period;
      mode_act     <= pwm_mode_e'(center_mode);
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      period_start <= boundary;
      if (boundary) begin
        per_act  <= period;
        mode_act <= pwm_mode_e'(center_mode);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .load  (load),
      .wr    (duty_wr[i]),
      .din   (duty_in[i]),
      .cnt   (cnt),
      .pwm   (PWM_sig[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi.
module tb_pwm_multi;
  localparam int W = 8;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                center_mode = 1'b0;
  logic [W-1:0]        period = '0;
  logic [N-1:0]        duty_wr = '0;
  logic [N-1:0][W-1:0] duty_in = '0;
  logic [N-1:0]        PWM_sig;
  logic                period_start;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .center_mode  (center_mode),
    .period       (period),
    .duty_wr      (duty_wr),
    .duty_in      (duty_in),
    .PWM_sig      (PWM_sig),
    .period_start (period_start)
  );

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load period/mode/duties with en low (transparent), leaving cnt at 0.
  task automatic configure(input logic [W-1:0] p, input logic cm,
                           input int d0, input int d1, input int d2, input int d3);
    en          = 1'b0;
    period      = p;
    center_mode = cm;
    duty_in[0]  = W'(d0);
    duty_in[1]  = W'(d1);
    duty_in[2]  = W'(d2);
    duty_in[3]  = W'(d3);
    duty_wr     = '1;
    step();
    duty_wr = '0;
    step();
  endtask

  task automatic test_reset();
    logic [W-1:0] dsum;
    rst_n      = 1'b0;
    en         = 1'b1;
    period     = 8'd9;
    duty_wr    = '1;
    duty_in[0] = 8'h55; duty_in[1] = 8'h55; duty_in[2] = 8'h55; duty_in[3] = 8'h55;
    for (int c = 0; c < 3; c++) begin
      step();
      if (PWM_sig !== 4'h0) begin
        n_err++; $display("FAIL reset_pwm cycle %0d: got %h want 0", c, PWM_sig);
      end
      n_vec++;
      if (period_start !== 1'b0) begin
        n_err++; $display("FAIL reset_ps cycle %0d: got %b want 0", c, period_start);
      end
      n_vec++;
    end
    rst_n   = 1'b1;
    en      = 1'b0;
    duty_wr = '0;
    step();
    dsum = dut.gen_ch[0].u_ch.duty_act | dut.gen_ch[1].u_ch.duty_act |
           dut.gen_ch[2].u_ch.duty_act | dut.gen_ch[3].u_ch.duty_act;
    if (dsum !== 8'h00) begin
      n_err++; $display("FAIL reset_duty_act: got %h want 00", dsum);
    end
    n_vec++;
    if (dut.cnt !== 8'h00) begin
      n_err++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt);
    end
    n_vec++;
  endtask

  task automatic test_edge();
    int d[N];
    int highs0;
    int ps_cnt;
    logic [N-1:0] exp_pwm;
    logic [W-1:0] exp_cnt;
    d[0] = 3; d[1] = 0; d[2] = 10; d[3] = 5;
    configure(8'd9, 1'b0, d[0], d[1], d[2], d[3]);
    en = 1'b1;
    highs0 = 0;
    ps_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      for (int i = 0; i < N; i++) exp_pwm[i] = (((k - 1) % 10) < d[i]);
      exp_cnt = W'(k % 10);
      if (PWM_sig !== exp_pwm) begin
        n_err++; $display("FAIL edge_pwm k=%0d: got %b want %b", k, PWM_sig, exp_pwm);
      end
      n_vec++;
      if (dut.cnt !== exp_cnt) begin
        n_err++; $display("FAIL edge_cnt k=%0d: got %0d want %0d", k, dut.cnt, exp_cnt);
      end
      n_vec++;
      if (period_start !== ((k % 10) == 0)) begin
        n_err++; $display("FAIL edge_ps k=%0d: got %b want %b", k, period_start, (k % 10) == 0);
      end
      n_vec++;
      highs0 += int'(PWM_sig[0]);
      ps_cnt += int'(period_start);
    end
    if (highs0 !== 9) begin
      n_err++; $display("FAIL edge_ch0_highs: got %0d want 9", highs0);
    end
    n_vec++;
    if (ps_cnt !== 3) begin
      n_err++; $display("FAIL edge_ps_count: got %0d want 3", ps_cnt);
    end
    n_vec++;
  endtask

  task automatic test_double_buffer();
    int exp_duty[4];
    int highs[4];
    int p;
    exp_duty[0] = 3; exp_duty[1] = 7; exp_duty[2] = 3; exp_duty[3] = 7;
    for (int i = 0; i < 4; i++) highs[i] = 0;
    configure(8'd9, 1'b0, 3, 0, 0, 0);
    en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      p = (k - 1) / 10;
      if (PWM_sig[0] !== (((k - 1) % 10) < exp_duty[p])) begin
        n_err++; $display("FAIL dbuf_pwm k=%0d: got %b want %b", k, PWM_sig[0],
                          ((k - 1) % 10) < exp_duty[p]);
      end
      n_vec++;
      highs[p] += int'(PWM_sig[0]);
      // Mid-period writes at cnt=4 and cnt=4; write-through on the boundary cycle (cnt=9).
      duty_wr = '0;
      if (k == 4)  begin duty_wr = 4'b0001; duty_in[0] = 8'd7; end
      if (k == 14) begin duty_wr = 4'b0001; duty_in[0] = 8'd3; end
      if (k == 29) begin duty_wr = 4'b0001; duty_in[0] = 8'd7; end
    end
    for (int i = 0; i < 4; i++) begin
      if (highs[i] !== exp_duty[i]) begin
        n_err++; $display("FAIL dbuf_highs period %0d: got %0d want %0d", i, highs[i], exp_duty[i]);
      end
      n_vec++;
    end
  endtask

  task automatic test_center();
    int seq[10];
    int highs0;
    logic [W-1:0] exp_cnt;
    seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 4;
    seq[5] = 5; seq[6] = 4; seq[7] = 3; seq[8] = 2; seq[9] = 1;
    configure(8'd5, 1'b1, 2, 2, 2, 2);
    en = 1'b1;
    highs0 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_cnt = W'(seq[k % 10]);
      if (dut.cnt !== exp_cnt) begin
        n_err++; $display("FAIL center_cnt k=%0d: got %0d want %0d", k, dut.cnt, exp_cnt);
      end
      n_vec++;
      if (PWM_sig[0] !== (seq[(k - 1) % 10] < 2)) begin
        n_err++; $display("FAIL center_pwm k=%0d: got %b want %b", k, PWM_sig[0], seq[(k - 1) % 10] < 2);
      end
      n_vec++;
      if (period_start !== ((k % 10) == 0)) begin
        n_err++; $display("FAIL center_ps k=%0d: got %b want %b", k, period_start, (k % 10) == 0);
      end
      n_vec++;
      highs0 += int'(PWM_sig[0]);
    end
    // k=1,2 (cnt 0,1), then k=10,11,12 and k=20: cnt 1,0,1 contiguous per period.
    if (highs0 !== 6) begin
      n_err++; $display("FAIL center_highs: got %0d want 6", highs0);
    end
    n_vec++;
  endtask

  task automatic test_mode_switch();
    int cseq[6];
    logic [W-1:0] exp_cnt;
    logic         exp_ps;
    cseq[0] = 0; cseq[1] = 1; cseq[2] = 2; cseq[3] = 3; cseq[4] = 2; cseq[5] = 1;
    configure(8'd9, 1'b0, 2, 2, 2, 2);
    en = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      exp_cnt = (k <= 10) ? W'(k % 10) : W'(cseq[(k - 10) % 6]);
      exp_ps  = (k == 10) || (k == 16) || (k == 22);
      if (dut.cnt !== exp_cnt) begin
        n_err++; $display("FAIL switch_cnt k=%0d: got %0d want %0d", k, dut.cnt, exp_cnt);
      end
      n_vec++;
      if (period_start !== exp_ps) begin
        n_err++; $display("FAIL switch_ps k=%0d: got %b want %b", k, period_start, exp_ps);
      end
      n_vec++;
      if (k == 4) begin
        period      = 8'd3;
        center_mode = 1'b1;
      end
    end
    // P=0: every cycle is a boundary and duty 1 keeps outputs high.
    configure(8'd0, 1'b0, 1, 1, 1, 1);
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (period_start !== 1'b1) begin
        n_err++; $display("FAIL p0_ps k=%0d: got %b want 1", k, period_start);
      end
      n_vec++;
      if (PWM_sig !== 4'hF) begin
        n_err++; $display("FAIL p0_pwm k=%0d: got %b want 1111", k, PWM_sig);
      end
      n_vec++;
      if (dut.cnt !== 8'd0) begin
        n_err++; $display("FAIL p0_cnt k=%0d: got %0d want 0", k, dut.cnt);
      end
      n_vec++;
    end
  endtask

  task automatic test_disruption();
    logic [N-1:0] exp_pwm;
    int d[N];
    d[0] = 3; d[1] = 0; d[2] = 10; d[3] = 5;
    configure(8'd9, 1'b0, d[0], d[1], d[2], d[3]);
    en = 1'b1;
    for (int k = 1; k <= 6; k++) step();
    rst_n = 1'b0;
    step();
    if (dut.cnt !== 8'd0) begin
      n_err++; $display("FAIL disrupt_rst_cnt: got %0d want 0", dut.cnt);
    end
    n_vec++;
    if (PWM_sig !== 4'h0) begin
      n_err++; $display("FAIL disrupt_rst_pwm: got %b want 0000", PWM_sig);
    end
    n_vec++;
    rst_n      = 1'b1;
    en         = 1'b0;
    duty_in[0] = W'(d[0]); duty_in[1] = W'(d[1]); duty_in[2] = W'(d[2]); duty_in[3] = W'(d[3]);
    duty_wr    = '1;
    for (int c = 0; c < 4; c++) begin
      step();
      duty_wr = '0;
      if (PWM_sig !== 4'h0 || period_start !== 1'b0) begin
        n_err++; $display("FAIL disrupt_en_out c=%0d: got %b/%b want 0000/0", c, PWM_sig, period_start);
      end
      n_vec++;
      if (dut.cnt !== 8'd0) begin
        n_err++; $display("FAIL disrupt_en_cnt c=%0d: got %0d want 0", c, dut.cnt);
      end
      n_vec++;
    end
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      for (int i = 0; i < N; i++) exp_pwm[i] = (((k - 1) % 10) < d[i]);
      if (dut.cnt !== W'(k % 10)) begin
        n_err++; $display("FAIL restart_cnt k=%0d: got %0d want %0d", k, dut.cnt, k % 10);
      end
      n_vec++;
      if (PWM_sig !== exp_pwm) begin
        n_err++; $display("FAIL restart_pwm k=%0d: got %b want %b", k, PWM_sig, exp_pwm);
      end
      n_vec++;
      if (period_start !== (k == 10)) begin
        n_err++; $display("FAIL restart_ps k=%0d: got %b want %b", k, period_start, k == 10);
      end
      n_vec++;
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_double_buffer();
    test_center();
    test_mode_switch();
    test_disruption();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised PWM generator; successor to the single 8-bit free-running PWM. Up to NUM_CH channels share one period counter with a programmable period and edge-aligned or center-aligned counting. Duty, period and mode updates are double-buffered so that they only take effect at a period boundary. The block sits between the control/register logic and the motor/LED drivers, one output per channel.

## Interface
- WIDTH, 8: width of the counter, period and each duty value.
- NUM_CH, 4: number of PWM channels.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  run enable; 0 holds the counter at 0 and forces outputs low.
- center_mode  input  1  0 selects edge-aligned, 1 selects center-aligned; latched at the boundary.
- period  input  WIDTH  period value P; latched at the boundary.
- duty_wr  input  NUM_CH  per-channel write strobe for the shadow duty register.
- duty_in  input  NUM_CH x WIDTH  per-channel duty value, captured when its strobe is high.
- PWM_sig  output  NUM_CH  registered PWM outputs.
- period_start  output  1  one-cycle pulse, registered, on the first cycle of each period.

## Operation
- State: cnt[WIDTH], dir (up/down), per_act, mode_act, and per channel duty_sh and duty_act.
- Edge mode: cnt runs 0,1,…,P and then returns to 0. The period is P+1 cycles.
- Center mode: cnt runs 0,1,…,P,P-1,…,1 and then returns to 0. The period is 2P cycles.
  - dir flips to down on the cycle cnt==P while counting up.
  - dir flips to up when cnt reaches 0.
- P==0 in either mode: cnt stays at 0 and every cycle is a boundary.
- Boundary: the clock edge on which the next cnt is 0, and cnt is nonzero or per_act==0. On a boundary edge:
  - per_act <= period
  - mode_act <= center_mode
  - duty_act[i] <= duty_sh[i]
  - period_start <= 1
- On every other edge, period_start <= 0.
- Shadow write: duty_wr[i] loads duty_sh[i] <= duty_in[i] at any time.
- Write on a boundary cycle: duty_act[i] takes duty_in[i] directly (write-through). The new value applies to the period that is starting.
- Compare: PWM_sig[i] <= en & (cnt < duty_act[i]), an unsigned WIDTH-bit compare.
  - duty 0: output always low.
  - duty > per_act: output always high.
  - No wrap-around arithmetic is performed.
- en=0, every cycle:
  - cnt <= 0 and dir <= up.
  - PWM_sig <= 0 and period_start <= 0.
  - per_act, mode_act and duty_act load from period, center_mode and duty_sh (transparent).
  - duty_sh writes are still accepted.
- en 0→1: the first enabled cycle uses cnt=0. period_start pulses on the edge that completes that first period.
- Reset (rst_n=0 at an edge): all of the following go to 0:
  - cnt, per_act, mode_act, all duty_sh, all duty_act
  - PWM_sig, period_start
  - dir goes to up.
- Reset overrides en and duty_wr. Reset mid-period abandons the period with no partial boundary.

## Timing
- PWM_sig lags cnt by one cycle (one register stage). PWM_sig is glitch-free: driven directly from a flop.
- A shadow write in cycle t is visible on PWM_sig no earlier than 2 cycles after the next boundary edge. The exception is a write-through on a boundary: visible 2 cycles after t.
- period_start is high for exactly 1 cycle per period, coincident with cnt==0 (the first cycle of the new period).
- A mode or period change mid-period has no effect until the boundary. The current period always completes with its latched P and mode.

## Structure
- pwm_pkg holds:
  - typedef enum logic {EDGE, CENTER} pwm_mode_e
  - localparam defaults for WIDTH and NUM_CH
- Sub-module pwm_channel, instantiated NUM_CH times via generate. It contains duty_sh, duty_act, write-through logic and the output compare flop.
- The counter, direction and boundary logic live once in pwm_multi.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with en=1 and duty_wr all 1. Required: PWM_sig==0, period_start==0, and after release all duty_act==0.
- Edge mode, P=9, duty ch0=3, ch1=0, ch2=10. Required:
  - ch0 high 3 of every 10 cycles.
  - ch1 constantly low.
  - ch2 constantly high.
  - period_start once per 10 cycles.
- Double buffer, edge mode, P=9: write ch0 3→7 when cnt=4. Required: the current period still gives 3 high cycles, the next period gives 7. Repeat with the write on the boundary cycle: 7 high in the starting period.
- Center mode, P=5, duty=2. Required:
  - cnt sequence 0,1,2,3,4,5,4,3,2,1.
  - ch0 high for 3 contiguous cycles (cnt 1,0,1) per 10-cycle period.
  - period_start every 10 cycles.
- Mode/period switch: change edge P=9 to center P=3 mid-period. Required: the current 10-cycle period completes unchanged, then 6-cycle center periods follow. P=0 with duty=1: output constantly high and period_start high every cycle.
- Disruption: assert rst_n=0 for one cycle at cnt=6. Required: next cnt=0 and PWM_sig=0. Drop en for 4 cycles. Required: outputs low, counter at 0, and a restart from cnt=0 when en returns.
